// File: rtl/tlut_pkg.sv
// Shared types, width helpers and the lane-max reduction for the temporal-LUT dot engine.
package tlut_pkg;

   typedef enum logic [1:0] {IDLE, RUN, ACC, OUT} state_t;

   function automatic int unsigned prod_w(input int unsigned iw, input int unsigned ww);
      return iw + ww;
   endfunction

   function automatic int unsigned acc_w(input int unsigned iw, input int unsigned ww,
                                         input int unsigned mb);
      return iw + ww + $clog2(mb);
   endfunction

   localparam int unsigned PROD_W = prod_w(4, 4);
   localparam int unsigned ACC_W  = acc_w(4, 4, 16);

   // Reduction operates on a fixed-size padded vector; lanes beyond DIM_A are zero.
   localparam int unsigned MAX_LANES = 16;
   localparam int unsigned MAX_VAL_W = 16;

   function automatic logic [MAX_VAL_W-1:0] max_of(
      input logic [MAX_LANES-1:0][MAX_VAL_W-1:0] v);
      logic [MAX_VAL_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (v[i] > m) m = v[i];
      end
      return m;
   endfunction

endpackage

// File: rtl/tlut_dot_engine_if.sv
// Operand-beat and result handshake bundle for the temporal-LUT dot engine.
interface tlut_dot_engine_if #(
   parameter int unsigned DIM_A        = 4,
   parameter int unsigned DIM_C        = 4,
   parameter int unsigned INPUT_WIDTH  = 4,
   parameter int unsigned WEIGHT_WIDTH = 4,
   parameter int unsigned ACC_W        = tlut_pkg::ACC_W
);
   logic                                       in_valid;
   logic                                       in_ready;
   logic                                       in_last;
   logic [DIM_A-1:0][INPUT_WIDTH-1:0]          input_bin;
   logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]         weight_bin;
   logic                                       out_valid;
   logic                                       out_ready;
   logic [DIM_C-1:0][DIM_A-1:0][ACC_W-1:0]     out_acc;
   logic                                       busy;

   modport master (
      output in_valid, in_last, input_bin, weight_bin, out_ready,
      input  in_ready, out_valid, out_acc, busy
   );

   modport slave (
      input  in_valid, in_last, input_bin, weight_bin, out_ready,
      output in_ready, out_valid, out_acc, busy
   );
endinterface

// File: rtl/tlut_lane_mul.sv
// One temporal multiply cell: captures the running weight sum while the input's unary bit is high.
module tlut_lane_mul #(
   parameter int unsigned INPUT_WIDTH = 4,
   parameter int unsigned PROD_W      = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   run,
   input  logic [INPUT_WIDTH-1:0] x,
   input  logic [INPUT_WIDTH-1:0] t,
   input  logic [PROD_W-1:0]      sum,
   output logic [PROD_W-1:0]      prod
);

   logic latch_en_c;

   assign latch_en_c = run && (x > t);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod <= '0;
      end else if (clear) begin
         prod <= '0;
      end else if (latch_en_c) begin
         prod <= sum;
      end
   end

endmodule

// File: rtl/tlut_dot_engine.sv
// Temporal-LUT SIMD dot-product engine: unary-stream multiply per beat, multi-beat accumulation,
// result handed off through a valid/ready output.
module tlut_dot_engine
   import tlut_pkg::*;
#(
   parameter int unsigned DIM_A        = 4,
   parameter int unsigned DIM_C        = 4,
   parameter int unsigned INPUT_WIDTH  = 4,
   parameter int unsigned WEIGHT_WIDTH = 4,
   parameter int unsigned SIGNED_W     = 0,
   parameter int unsigned MAX_BEATS    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   tlut_dot_engine_if.slave  bus
);

   localparam int unsigned PW = prod_w(INPUT_WIDTH, WEIGHT_WIDTH);
   localparam int unsigned AW = acc_w(INPUT_WIDTH, WEIGHT_WIDTH, MAX_BEATS);

   state_t                                 state;
   logic                                   in_ready_r;
   logic                                   out_valid_r;
   logic                                   busy_r;
   logic [DIM_A-1:0][INPUT_WIDTH-1:0]      x_r;
   logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]     w_r;
   logic                                   last_r;
   logic [INPUT_WIDTH-1:0]                 max_r;
   logic [INPUT_WIDTH-1:0]                 t;
   logic [DIM_C-1:0][PW-1:0]               wacc;
   logic [DIM_C-1:0][PW-1:0]               w_ext;
   logic [DIM_C-1:0][PW-1:0]               wsum;
   logic [DIM_C-1:0][DIM_A-1:0][PW-1:0]    prod;
   logic [DIM_C-1:0][DIM_A-1:0][AW-1:0]    prod_ext;
   logic [DIM_C-1:0][DIM_A-1:0][AW-1:0]    acc;
   logic [MAX_LANES-1:0][MAX_VAL_W-1:0]    pad_in;
   logic [INPUT_WIDTH-1:0]                 max_in_c;
   logic                                   accept_c;
   logic                                   run_c;

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.out_acc   = acc;

   // Beat length is the largest input across lanes.
   always_comb begin
      pad_in = '0;
      for (int i = 0; i < int'(DIM_A); i++) begin
         pad_in[i] = MAX_VAL_W'(bus.input_bin[i]);
      end
   end

   assign max_in_c = INPUT_WIDTH'(max_of(pad_in));
   assign accept_c = bus.in_valid && in_ready_r;
   assign run_c    = (state == RUN);

   for (genvar j = 0; j < int'(DIM_C); j++) begin : g_row
      if (SIGNED_W != 0) begin : g_sgn
         assign w_ext[j] = PW'($signed(w_r[j]));
         for (genvar i = 0; i < int'(DIM_A); i++) begin : g_ext
            assign prod_ext[j][i] = AW'($signed(prod[j][i]));
         end
      end else begin : g_uns
         assign w_ext[j] = PW'(w_r[j]);
         for (genvar i = 0; i < int'(DIM_A); i++) begin : g_ext
            assign prod_ext[j][i] = AW'(prod[j][i]);
         end
      end

      assign wsum[j] = wacc[j] + w_ext[j];

      for (genvar i = 0; i < int'(DIM_A); i++) begin : g_col
         tlut_lane_mul #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .PROD_W      (PW)
         ) u_mul (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (accept_c),
            .run   (run_c),
            .x     (x_r[i]),
            .t     (t),
            .sum   (wsum[j]),
            .prod  (prod[j][i])
         );
      end
   end

   // Control FSM, ramp counter, weight accumulators and dot-product accumulators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         x_r         <= '0;
         w_r         <= '0;
         last_r      <= 1'b0;
         max_r       <= '0;
         t           <= '0;
         wacc        <= '0;
         acc         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  x_r        <= bus.input_bin;
                  w_r        <= bus.weight_bin;
                  last_r     <= bus.in_last;
                  max_r      <= max_in_c;
                  t          <= '0;
                  wacc       <= '0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= (max_in_c != '0) ? RUN : ACC;
               end
            end
            RUN: begin
               wacc <= wsum;
               t    <= t + INPUT_WIDTH'(1);
               if (t == max_r - INPUT_WIDTH'(1)) state <= ACC;
            end
            ACC: begin
               for (int j = 0; j < int'(DIM_C); j++) begin
                  for (int i = 0; i < int'(DIM_A); i++) begin
                     acc[j][i] <= acc[j][i] + prod_ext[j][i];
                  end
               end
               if (last_r) begin
                  out_valid_r <= 1'b1;
                  state       <= OUT;
               end else begin
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
                  state      <= IDLE;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  acc         <= '0;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlut_dot_engine.sv
// Randomised bench for tlut_dot_engine: unsigned and signed-weight instances share the same
// stimulus and are checked against a plain-arithmetic sum-of-products model.
module tb_tlut_dot_engine;

   localparam int unsigned NA    = 4;
   localparam int unsigned NC    = 4;
   localparam int unsigned IW    = 4;
   localparam int unsigned WW    = 4;
   localparam int unsigned AW    = tlut_pkg::ACC_W;
   localparam int          BOUND = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   tlut_dot_engine_if #(.DIM_A(NA), .DIM_C(NC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .ACC_W(AW)) ifu ();
   tlut_dot_engine_if #(.DIM_A(NA), .DIM_C(NC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .ACC_W(AW)) ifs ();

   tlut_dot_engine #(.DIM_A(NA), .DIM_C(NC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW),
                     .SIGNED_W(0), .MAX_BEATS(16)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(ifu));
   tlut_dot_engine #(.DIM_A(NA), .DIM_C(NC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW),
                     .SIGNED_W(1), .MAX_BEATS(16)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs));

   int     checks = 0;
   int     errors = 0;
   longint sum_u [NC][NA];
   longint sum_s [NC][NA];

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [NA-1:0][IW-1:0] x, input logic [NC-1:0][WW-1:0] w,
                        input logic valid, input logic last);
      ifu.input_bin = x;  ifs.input_bin = x;
      ifu.weight_bin = w; ifs.weight_bin = w;
      ifu.in_valid = valid; ifs.in_valid = valid;
      ifu.in_last = last; ifs.in_last = last;
   endtask

   task automatic set_ready(input logic r);
      ifu.out_ready = r;
      ifs.out_ready = r;
   endtask

   function automatic int max_x(input logic [NA-1:0][IW-1:0] x);
      int m = 0;
      for (int i = 0; i < NA; i++) if (int'(x[i]) > m) m = int'(x[i]);
      return m;
   endfunction

   task automatic clear_model();
      for (int j = 0; j < NC; j++)
         for (int i = 0; i < NA; i++) begin
            sum_u[j][i] = 0;
            sum_s[j][i] = 0;
         end
   endtask

   task automatic add_model(input logic [NA-1:0][IW-1:0] x, input logic [NC-1:0][WW-1:0] w);
      int ws;
      for (int j = 0; j < NC; j++) begin
         ws = int'(w[j]);
         if (w[j][WW-1]) ws = ws - (1 << WW);
         for (int i = 0; i < NA; i++) begin
            sum_u[j][i] += longint'(w[j]) * longint'(x[i]);
            sum_s[j][i] += longint'(ws) * longint'(x[i]);
         end
      end
   endtask

   task automatic check_acc(input string tag);
      for (int j = 0; j < NC; j++)
         for (int i = 0; i < NA; i++) begin
            check($sformatf("%s_u%0d%0d", tag, j, i), longint'(ifu.out_acc[j][i]), sum_u[j][i] & 64'hFFF);
            check($sformatf("%s_s%0d%0d", tag, j, i), longint'(ifs.out_acc[j][i]), sum_s[j][i] & 64'hFFF);
         end
   endtask

   // Called at a falling edge; returns at the falling edge where the beat's completion is visible.
   task automatic do_beat(input logic [NA-1:0][IW-1:0] x, input logic [NC-1:0][WW-1:0] w,
                          input logic last, input logic early);
      int n;
      int cyc;
      logic [NA-1:0][IW-1:0] gx;
      logic [NC-1:0][WW-1:0] gw;
      drive(x, w, 1'b1, last);
      if (last) set_ready(1'b0);
      else set_ready(1'($urandom_range(0, 1)));
      n = 0;
      while (!ifu.in_ready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check("rdy_wait", longint'(ifu.in_ready), 1);
      @(posedge clk);
      add_model(x, w);
      @(negedge clk);
      if (early && !last) begin
         gx = IW*NA'($urandom);
         gw = WW*NC'($urandom);
         drive(gx, gw, 1'b1, 1'b0);
      end else begin
         drive(x, w, 1'b0, 1'b0);
      end
      check("busy", longint'(ifu.busy), 1);
      check("in_ready_lo", longint'(ifu.in_ready), 0);
      cyc = 1;
      while (!(last ? ifu.out_valid : ifu.in_ready) && cyc < BOUND) begin
         @(negedge clk);
         cyc++;
      end
      check(last ? "lat_out" : "lat_rdy", longint'(cyc), longint'(max_x(x) + 2));
      check("sync_s", longint'(last ? ifs.out_valid : ifs.in_ready), 1);
   endtask

   // Called at the falling edge where out_valid first shows; drains the result.
   task automatic finish_txn(input int bp, input string tag);
      int j;
      int i;
      check_acc(tag);
      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         j = k % NC;
         i = (k / NC) % NA;
         check("bp_valid", longint'(ifu.out_valid), 1);
         check("bp_acc_u", longint'(ifu.out_acc[j][i]), sum_u[j][i] & 64'hFFF);
         check("bp_acc_s", longint'(ifs.out_acc[j][i]), sum_s[j][i] & 64'hFFF);
      end
      set_ready(1'b1);
      @(negedge clk);
      check("drain_valid", longint'(ifu.out_valid), 0);
      check("drain_ready", longint'(ifu.in_ready), 1);
      check("drain_busy", longint'(ifu.busy), 0);
      check("drain_clr_u", longint'(ifu.out_acc != '0), 0);
      check("drain_clr_s", longint'(ifs.out_acc != '0), 0);
      set_ready(1'b0);
      clear_model();
   endtask

   initial begin
      logic [NA-1:0][IW-1:0] x;
      logic [NC-1:0][WW-1:0] w;
      int nb;

      x = '0;
      w = '0;
      drive(x, w, 1'b0, 1'b0);
      set_ready(1'b0);
      clear_model();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", longint'(ifu.in_ready), 1);
      check("rst_valid", longint'(ifu.out_valid), 0);
      check("rst_busy", longint'(ifu.busy), 0);
      check("rst_acc", longint'(ifu.out_acc != '0), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single unsigned beat
      x[0] = 4'd3; x[1] = 4'd0; x[2] = 4'd5; x[3] = 4'd1;
      w[0] = 4'd2; w[1] = 4'd7; w[2] = 4'd0; w[3] = 4'd15;
      do_beat(x, w, 1'b1, 1'b0);
      check("t1_35", longint'(ifu.out_acc[1][2]), 35);
      check("t1_45", longint'(ifu.out_acc[3][0]), 45);
      for (int j = 0; j < NC; j++) check("t1_col1", longint'(ifu.out_acc[j][1]), 0);
      finish_txn(0, "t1");

      // two beats, second pre-driven while the first is busy
      x = {4'd1, 4'd1, 4'd1, 4'd1}; w = {4'd3, 4'd3, 4'd3, 4'd3};
      do_beat(x, w, 1'b0, 1'b1);
      x = {4'd2, 4'd2, 4'd2, 4'd2}; w = {4'd4, 4'd4, 4'd4, 4'd4};
      do_beat(x, w, 1'b1, 1'b0);
      check("t2_11", longint'(ifu.out_acc[2][3]), 11);
      finish_txn(2, "t2");

      // negative weight with the longest beat
      x = {4'd2, 4'd7, 4'd0, 4'd15}; w = {4'd1, 4'd5, 4'd9, 4'd8};
      do_beat(x, w, 1'b1, 1'b0);
      check("t3_neg", longint'(ifs.out_acc[0][0]), 4096 - 120);
      check("t3_pos", longint'(ifu.out_acc[0][0]), 120);
      finish_txn(1, "t3");

      // zero-length beat
      x = '0; w = {4'd9, 4'd8, 4'd7, 4'd6};
      do_beat(x, w, 1'b1, 1'b0);
      finish_txn(0, "t4");

      // long backpressure, then a fresh single beat
      x = {4'd4, 4'd3, 4'd2, 4'd1}; w = {4'd11, 4'd5, 4'd13, 4'd2};
      do_beat(x, w, 1'b1, 1'b0);
      finish_txn(10, "t5");
      x = {4'd1, 4'd1, 4'd1, 4'd1}; w = {4'd1, 4'd1, 4'd1, 4'd1};
      do_beat(x, w, 1'b1, 1'b0);
      check("t5_one", longint'(ifu.out_acc[0][0]), 1);
      finish_txn(0, "t5b");

      // reset in the middle of a second beat discards the partial sum
      x = {4'd6, 4'd2, 4'd9, 4'd3}; w = {4'd7, 4'd14, 4'd3, 4'd10};
      do_beat(x, w, 1'b0, 1'b0);
      x = {4'd15, 4'd15, 4'd15, 4'd15};
      drive(x, w, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(x, w, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      check("mid_busy", longint'(ifu.busy), 1);
      rst_n = 1'b0;
      #1;
      check("mrst_ready", longint'(ifu.in_ready), 1);
      check("mrst_valid", longint'(ifu.out_valid), 0);
      check("mrst_busy", longint'(ifu.busy), 0);
      check("mrst_acc_u", longint'(ifu.out_acc != '0), 0);
      check("mrst_acc_s", longint'(ifs.out_acc != '0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      @(negedge clk);
      x = {4'd1, 4'd1, 4'd1, 4'd1}; w = {4'd1, 4'd1, 4'd1, 4'd1};
      do_beat(x, w, 1'b1, 1'b0);
      check("t6_one", longint'(ifu.out_acc[3][3]), 1);
      finish_txn(0, "t6");

      // randomised multi-beat dot products
      for (int tr = 0; tr < 25; tr++) begin
         nb = int'($urandom_range(1, 4));
         for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < NA; i++)
               x[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : IW'($urandom_range(1, 15));
            for (int j = 0; j < NC; j++) w[j] = WW'($urandom);
            do_beat(x, w, 1'(b == nb - 1), 1'($urandom_range(0, 1)));
         end
         finish_txn(int'($urandom_range(0, 3)), $sformatf("r%0d", tr));
      end

      // more beats than MAX_BEATS, accumulator wraps
      x = {4'd15, 4'd15, 4'd15, 4'd15}; w = {4'd15, 4'd15, 4'd15, 4'd15};
      for (int b = 0; b < 20; b++) do_beat(x, w, 1'(b == 19), 1'b0);
      finish_txn(0, "wrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tlut_dot_engine.md
Name: tlut_dot_engine

Overview:
- Parametrised temporal-LUT SIMD dot-product engine for a DIM_A x DIM_C tile.
- Each accepted operand beat converts every input to a temporal (unary) stream using a shared ramp counter. A running weight accumulator is latched wherever the temporal bit is high, so each product equals weight*input.
- The products of successive beats are summed into per-lane dot-product accumulators until a beat tagged last. The result is then presented through a valid/ready output.
- Adds three things the previous cell lacked:
  - early termination at the beat's max input;
  - signed-weight mode;
  - multi-beat accumulation with handshakes.

Parameters:
DIM_A, 4, number of input lanes
DIM_C, 4, number of weight lanes
INPUT_WIDTH, 4, unsigned input width (temporal length up to 2^INPUT_WIDTH-1 cycles)
WEIGHT_WIDTH, 4, weight width
SIGNED_W, 0, 1 = weights are two's complement; 0 = unsigned
MAX_BEATS, 16, maximum beats per dot product (sizes accumulator)
PROD_W, INPUT_WIDTH+WEIGHT_WIDTH, product width (derived)
ACC_W, PROD_W+$clog2(MAX_BEATS), output accumulator width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  engine can accept a beat
in_last  in  1  beat closes the current dot product
input_bin  in  DIM_A x INPUT_WIDTH  unsigned inputs
weight_bin  in  DIM_C x WEIGHT_WIDTH  weights (signedness per SIGNED_W)
out_valid  out  1  dot-product result valid
out_ready  in  1  downstream accepts result
out_acc  out  DIM_C x DIM_A x ACC_W  result, element [j][i] = sum over beats of w[j]*x[i]
busy  out  1  high in any state except IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, all registers 0, in_ready=1, out_valid=0, out_acc=0, busy=0.
- in_ready=1 only in IDLE.
- Accept occurs when in_valid && in_ready. On accept, register:
  - input_bin, weight_bin, in_last;
  - max_in = max over i of input_bin[i], computed combinationally at accept;
  - ramp counter t=0, weight accumulator wacc=0, product regs=0.
- FSM states: IDLE, RUN, ACC, OUT.
  - IDLE -> RUN on accept if max_in!=0.
  - IDLE -> ACC on accept if max_in==0 (zero-length beat, products stay 0).
  - RUN, each cycle:
    - wacc[j] <= wacc[j]+w[j];
    - for every i with x[i] > t: prod[j][i] <= wacc[j]+w[j], otherwise hold;
    - t <= t+1.
    - RUN -> ACC when t==max_in-1 (early termination; RUN lasts exactly max_in cycles).
  - ACC (1 cycle): acc[j][i] <= acc[j][i] + sign/zero-extended prod[j][i].
    - ACC -> OUT if last, else -> IDLE.
  - OUT: out_valid=1. out_acc is stable while out_valid && !out_ready.
    - When out_ready: accumulators clear to 0, -> IDLE.
- Latency:
  - Beat accepted in cycle 0: ACC in cycle max_in+1 (cycle 1 if max_in==0).
  - For a last beat, out_valid is asserted from cycle max_in+2.
  - Non-last beat throughput: max_in+2 cycles per beat.
- Arithmetic:
  - wacc and prod are PROD_W wide, signed when SIGNED_W=1.
  - The accumulator is ACC_W wide and wraps modulo 2^ACC_W.
  - More than MAX_BEATS beats is legal; overflow wraps, no flag.
- Boundary conditions:
  - x[i]=0: lane product 0.
  - Input all-ones: RUN runs the full 2^INPUT_WIDTH-1 cycles, and t never wraps.
  - Negative weight, SIGNED_W=1: product is negative and correctly sign-extended.
  - in_valid asserted outside IDLE: ignored, not lost (source holds it until in_ready).
  - out_ready asserted while not OUT: no effect.
  - Reset mid-RUN/ACC/OUT: immediate return to reset values; the partial dot product is discarded.

Decomposition:
- Shared package tlut_pkg holds:
  - state enum (IDLE, RUN, ACC, OUT);
  - derived width localparams PROD_W and ACC_W;
  - the max-reduction function used for max_in.
- One natural sub-module: tlut_lane_mul, a per-(j,i) temporal multiply cell. It has the prod register, the x[i]>t compare and the latch enable, instantiated DIM_C x DIM_A in a generate.
- Ramp counter, wacc, FSM and accumulators stay in the top.

Test Plan:
- Single last beat, x={3,0,5,1}, w={2,7,0,15} unsigned -> out_acc[1][2]=35, [3][0]=45, column i=1 all 0; out_valid at accept+7 (max_in=5).
- Two beats, x={1,1,1,1}/w=all 3 then x={2,2,2,2}/w=all 4 (last) -> every out_acc element =11; in_ready low during each beat's RUN/ACC.
- SIGNED_W=1, w[0]=-8 (4'b1000), x[0]=15 -> out_acc[0][0]=-120 sign-extended; RUN lasts 15 cycles.
- All-zero inputs, last -> no RUN cycles; out_valid at accept+2; out_acc all 0.
- Backpressure: out_ready held low 10 cycles in OUT -> out_valid and out_acc stable. Then out_ready=1 -> out_valid drops next cycle, and a following single beat x=1,w=1 yields 1, not an accumulated value.
- Assert rst_n low mid-RUN -> all outputs 0 asynchronously, state IDLE, in_ready=1. The next beat computes from a clean accumulator.
